// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bundle: imem request/response, decode handshake, redirect.
// The slave side is the fetch unit; the master side is cache plus decode.
interface fetch_prefetch_queue_if;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        deq;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_npc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_halted;

    modport slave (
        input  ihit,
        input  imemload,
        input  deq,
        input  redirect,
        input  redirect_pc,
        output imemREN,
        output imemaddr,
        output out_valid,
        output out_instr,
        output out_pc,
        output out_npc,
        output fetch_halted
    );

    modport master (
        output ihit,
        output imemload,
        output deq,
        output redirect,
        output redirect_pc,
        input  imemREN,
        input  imemaddr,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  out_npc,
        input  fetch_halted
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: owns the PC, reads imem, queues {pc, instr} for decode.
// Redirect flushes everything; a fetched HALT stops further requests.
module fetch_prefetch_queue #(
    parameter logic [31:0] PC_INIT = 32'h0,
    parameter int          DEPTH   = 4,
    parameter logic [5:0]  HALT_OP = 6'h3F
) (
    input logic CLK,
    input logic nRST,
    fetch_prefetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic          halted;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [31:0] mem_pc    [DEPTH];
    logic [31:0] mem_instr [DEPTH];

    logic ren;
    logic valid;
    logic push;
    logic pop;
    logic is_halt;

    assign ren     = (count < FULL_CNT) && !halted;
    assign valid   = (count != '0);
    assign push    = ren && bus.ihit && !bus.redirect;
    assign pop     = bus.deq && valid && !bus.redirect;
    assign is_halt = (bus.imemload[31:26] == HALT_OP);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_pc <= PC_INIT;
            halted   <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            halted   <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                tail     <= tail + PW'(1);
                if (is_halt) halted <= 1'b1;
            end
            if (pop) head <= head + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_pc[tail]    <= fetch_pc;
            mem_instr[tail] <= bus.imemload;
        end
    end

    assign bus.imemREN      = ren;
    assign bus.imemaddr     = fetch_pc;
    assign bus.out_valid    = valid;
    assign bus.out_instr    = mem_instr[head];
    assign bus.out_pc       = mem_pc[head];
    assign bus.out_npc      = mem_pc[head] + 32'd4;
    assign bus.fetch_halted = halted;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue at DEPTH=4, PC_INIT=0.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_fetch_prefetch_queue;
    logic CLK;
    logic nRST;
    int   n_cmp;
    int   n_bad;

    fetch_prefetch_queue_if bus ();

    fetch_prefetch_queue #(
        .PC_INIT (32'h0),
        .DEPTH   (4),
        .HALT_OP (6'h3F)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic ih, input logic [31:0] ld,
                         input logic dq);
        bus.ihit     = ih;
        bus.imemload = ld;
        bus.deq      = dq;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nRST            = 1'b0;
        bus.ihit        = 1'b0;
        bus.imemload    = 32'h0;
        bus.deq         = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        #12;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ren", 32'(bus.imemREN), 32'd1);
        chk("rst_addr", bus.imemaddr, 32'h0);
        chk("rst_halted", 32'(bus.fetch_halted), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        // Fill the queue with ihit every cycle
        drive(1'b1, 32'h1100_0000, 1'b0);
        tick();
        chk("fill1_valid", 32'(bus.out_valid), 32'd1);
        chk("fill1_pc", bus.out_pc, 32'h0);
        chk("fill1_instr", bus.out_instr, 32'h1100_0000);
        chk("fill1_npc", bus.out_npc, 32'h4);
        chk("fill1_addr", bus.imemaddr, 32'h4);
        drive(1'b1, 32'h1100_0001, 1'b0);
        tick();
        drive(1'b1, 32'h1100_0002, 1'b0);
        tick();
        chk("fill3_ren", 32'(bus.imemREN), 32'd1);
        drive(1'b1, 32'h1100_0003, 1'b0);
        tick();
        chk("full_ren", 32'(bus.imemREN), 32'd0);
        chk("full_addr", bus.imemaddr, 32'h10);
        chk("full_pc", bus.out_pc, 32'h0);
        chk("full_npc", bus.out_npc, 32'h4);
        drive(1'b1, 32'hDEAD_0000, 1'b0);
        tick();
        chk("full_ign_addr", bus.imemaddr, 32'h10);
        chk("full_ign_instr", bus.out_instr, 32'h1100_0000);

        // Full with deq and ihit: pop only, then push+pop
        drive(1'b1, 32'h1100_0004, 1'b1);
        tick();
        chk("pop_only_pc", bus.out_pc, 32'h4);
        chk("pop_only_instr", bus.out_instr, 32'h1100_0001);
        chk("pop_only_ren", 32'(bus.imemREN), 32'd1);
        chk("pop_only_addr", bus.imemaddr, 32'h10);
        drive(1'b1, 32'h1100_0004, 1'b1);
        tick();
        chk("pp_pc", bus.out_pc, 32'h8);
        chk("pp_addr", bus.imemaddr, 32'h14);
        chk("pp_ren", 32'(bus.imemREN), 32'd1);

        // Redirect with 3 queued, ihit and deq discarded
        drive(1'b1, 32'hBAD0_0000, 1'b1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h203;
        tick();
        bus.redirect = 1'b0;
        chk("redir_valid", 32'(bus.out_valid), 32'd0);
        chk("redir_addr", bus.imemaddr, 32'h200);
        chk("redir_ren", 32'(bus.imemREN), 32'd1);
        drive(1'b1, 32'h2200_0000, 1'b0);
        tick();
        chk("redir_push_pc", bus.out_pc, 32'h200);
        chk("redir_push_instr", bus.out_instr, 32'h2200_0000);
        chk("redir_push_addr", bus.imemaddr, 32'h204);

        // HALT at 0x40
        drive(1'b0, 32'h0, 1'b0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h3C;
        tick();
        bus.redirect = 1'b0;
        drive(1'b1, 32'h2000_0000, 1'b0);
        tick();
        drive(1'b1, 32'hFC00_0000, 1'b0);
        tick();
        chk("halt_flag", 32'(bus.fetch_halted), 32'd1);
        chk("halt_ren", 32'(bus.imemREN), 32'd0);
        chk("halt_addr", bus.imemaddr, 32'h44);
        drive(1'b1, 32'h3300_0000, 1'b0);
        tick();
        chk("halt_ign_addr", bus.imemaddr, 32'h44);
        chk("halt_head_pc", bus.out_pc, 32'h3C);
        drive(1'b0, 32'h0, 1'b1);
        tick();
        chk("halt_drain_valid", 32'(bus.out_valid), 32'd1);
        chk("halt_drain_pc", bus.out_pc, 32'h40);
        chk("halt_drain_instr", bus.out_instr, 32'hFC00_0000);
        tick();
        chk("halt_empty", 32'(bus.out_valid), 32'd0);
        chk("halt_still", 32'(bus.fetch_halted), 32'd1);
        drive(1'b0, 32'h0, 1'b0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h80;
        tick();
        bus.redirect = 1'b0;
        chk("resume_halted", 32'(bus.fetch_halted), 32'd0);
        chk("resume_ren", 32'(bus.imemREN), 32'd1);
        chk("resume_addr", bus.imemaddr, 32'h80);

        // ihit three cycles late per request
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 3; w++) begin
                drive(1'b0, 32'h0, 1'b0);
                tick();
                chk("late_addr", bus.imemaddr, 32'h80 + 32'(4 * r));
                chk("late_valid", 32'(bus.out_valid), 32'(r));
            end
            drive(1'b1, 32'h4400_0000 + 32'(r), 1'b0);
            tick();
            chk("late_push_addr", bus.imemaddr, 32'h84 + 32'(4 * r));
            chk("late_head_pc", bus.out_pc, 32'h80);
        end
        drive(1'b0, 32'h0, 1'b1);
        tick();
        chk("late_pc2", bus.out_pc, 32'h84);
        chk("late_instr2", bus.out_instr, 32'h4400_0001);
        tick();
        chk("late_empty", 32'(bus.out_valid), 32'd0);

        // Pointer wrap: one primer, then 10 push/pop pairs
        drive(1'b1, 32'h5500_0000, 1'b0);
        tick();
        chk("wrap_prime_pc", bus.out_pc, 32'h88);
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 32'h5500_0000 + 32'(k), 1'b1);
            tick();
            chk("wrap_pc", bus.out_pc, 32'h88 + 32'(4 * k));
            chk("wrap_instr", bus.out_instr, 32'h5500_0000 + 32'(k));
        end
        chk("wrap_addr", bus.imemaddr, 32'h88 + 32'd44);
        drive(1'b0, 32'h0, 1'b1);
        tick();
        chk("wrap_empty", 32'(bus.out_valid), 32'd0);
        tick();
        chk("deq_empty_valid", 32'(bus.out_valid), 32'd0);
        chk("deq_empty_addr", bus.imemaddr, 32'h88 + 32'd44);

        // Async reset mid-request, late ihit accepted as PC_INIT word
        drive(1'b0, 32'h0, 1'b0);
        #2;
        nRST = 1'b0;
        #1;
        chk("mid_rst_addr", bus.imemaddr, 32'h0);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        drive(1'b1, 32'h6600_0000, 1'b0);
        tick();
        chk("post_rst_pc", bus.out_pc, 32'h0);
        chk("post_rst_instr", bus.out_instr, 32'h6600_0000);
        chk("post_rst_addr", bus.imemaddr, 32'h4);
        drive(1'b0, 32'h0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
